// File: rtl/fp_pkg.sv
// Shared constants and state type for the FP adder normalizer.
// Optional rounding is enabled by defining FP_NORM_ROUND_EN.
package fp_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int MANT_W = MAN_W + 5;
  localparam int FP_EXP_MAX = (1 << EXP_W) - 1;
  localparam int CARRY_BIT = MAN_W + 4;
  localparam int HIDDEN_BIT = MAN_W + 3;
  localparam int G_BIT = 2;
  localparam int R_BIT = 1;
  localparam int S_BIT = 0;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SHIFT,
    ROUND,
    DONE
  } norm_state_t;
endpackage

// File: rtl/fp_round.sv
// Round-to-nearest-even incrementer on the {carry,hidden,fraction} field.
// Used by fp_normalizer only when FP_NORM_ROUND_EN is defined.
module fp_round
  import fp_pkg::*;
#(
  parameter int MW = MAN_W
) (
  input  logic [MW+4:0] mant,
  output logic [MW+1:0] rounded,
  output logic          carry
);
  logic inc;

  assign inc = mant[G_BIT] & (mant[R_BIT] | mant[S_BIT] | mant[G_BIT+1]);
  assign rounded = mant[MW+4:G_BIT+1] + {{(MW+1){1'b0}}, inc};
  assign carry = rounded[MW+1];
endmodule

// File: rtl/fp_normalizer.sv
// Post-add normalizer: bit-serial shift, round, overflow/underflow rules.
// Define FP_NORM_ROUND_EN for round-to-nearest-even; default truncates.
module fp_normalizer
  import fp_pkg::*;
#(
  parameter int EW = EXP_W,
  parameter int MW = MAN_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic [EW-1:0] in_exp,
  input  logic [MW+4:0] in_mant,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_result,
  output logic          out_overflow,
  output logic          out_underflow,
  output logic          busy
);
  localparam int MT = MW + 5;
  localparam logic [EW:0] ONE = (EW+1)'(1);
  localparam logic [EW:0] EMAX = (EW+1)'((1 << EW) - 1);

  norm_state_t state_q, state_d;
  logic          sign_q, sign_d;
  logic [EW:0]   exp_q, exp_d;
  logic [MT-1:0] mant_q, mant_d;
  logic          unf_q, unf_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   res_q, res_d;
  logic [EW:0]   exp_inc, exp_dec;
  logic [MT-1:0] shl;
  logic [EW-1:0] ef;
  logic [31:0]   inf;

`ifdef FP_NORM_ROUND_EN
  logic [MW+1:0] rnd;
  logic          rnd_c;

  fp_round #(.MW(MW)) u_round (
    .mant    (mant_q),
    .rounded (rnd),
    .carry   (rnd_c)
  );
`endif

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    unf_d   = unf_q;
    ovf_d   = ovf_q;
    res_d   = res_q;
    exp_inc = exp_q + ONE;
    exp_dec = exp_q - ONE;
    shl     = {mant_q[MT-2:0], 1'b0};
    ef      = unf_q ? '0 : exp_q[EW-1:0];
    inf     = {sign_q, {EW{1'b1}}, {MW{1'b0}}};
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          exp_d   = {1'b0, in_exp};
          mant_d  = in_mant;
          unf_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (mant_q == '0) begin
          res_d   = '0;
          state_d = DONE;
        end else if (mant_q[CARRY_BIT]) begin
          // Right shift keeps the dropped bit alive in sticky.
          mant_d = {1'b0, mant_q[MT-1:2], mant_q[1] | mant_q[0]};
          exp_d  = exp_inc;
          if (exp_inc >= EMAX) begin
            ovf_d   = 1'b1;
            res_d   = inf;
            state_d = DONE;
          end else begin
            state_d = ROUND;
          end
        end else if (mant_q[HIDDEN_BIT]) begin
          state_d = ROUND;
        end else if (exp_q <= ONE) begin
          unf_d   = 1'b1;
          state_d = ROUND;
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        mant_d = shl;
        exp_d  = exp_dec;
        if (shl[HIDDEN_BIT]) begin
          state_d = ROUND;
        end else if (exp_dec == ONE) begin
          unf_d   = 1'b1;
          state_d = ROUND;
        end
      end
      ROUND: begin
`ifdef FP_NORM_ROUND_EN
        if (rnd_c) begin
          if (exp_inc >= EMAX) begin
            ovf_d = 1'b1;
            res_d = inf;
          end else begin
            res_d = {sign_q, exp_inc[EW-1:0], rnd[MW:1]};
          end
        end else if (unf_q && rnd[MW]) begin
          unf_d = 1'b0;
          res_d = {sign_q, EW'(1), rnd[MW-1:0]};
        end else begin
          res_d = {sign_q, ef, rnd[MW-1:0]};
        end
`else
        res_d = {sign_q, ef, mant_q[HIDDEN_BIT-1:G_BIT+1]};
`endif
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      unf_q   <= 1'b0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      unf_q   <= unf_d;
      ovf_q   <= ovf_d;
      res_q   <= res_d;
    end
  end

  assign in_ready      = state_q == IDLE;
  assign out_valid     = state_q == DONE;
  assign busy          = state_q != IDLE;
  assign out_result    = res_q;
  assign out_overflow  = ovf_q & out_valid;
  assign out_underflow = unf_q & out_valid;
endmodule

// File: tb/tb_fp_normalizer.sv
// Directed-vector bench for fp_normalizer (both FP_NORM_ROUND_EN builds).
module tb_fp_normalizer;
  import fp_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [27:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;
  logic        busy;

  int checks = 0;
  int errors = 0;

  fp_normalizer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_mant       (in_mant),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                        input logic [27:0] m, input logic [31:0] res,
                        input logic ovf, input logic unf, input int lat,
                        input int hold);
    int n;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_lat"}, n, lat);
    check({tag, "_res"}, out_result, res);
    check({tag, "_ovf"}, {31'd0, out_overflow}, {31'd0, ovf});
    check({tag, "_unf"}, {31'd0, out_underflow}, {31'd0, unf});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_v"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_hold_r"}, out_result, res);
      check({tag, "_hold_ir"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", out_result, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("norm", 0, 8'h7F, 28'h4000000, 32'h3F800000, 0, 0, 3, 5);
    run_op("carry", 0, 8'h7F, 28'h8000000, 32'h40000000, 0, 0, 3, 0);
    run_op("ovf", 0, 8'hFE, 28'h8000000, 32'h7F800000, 1, 0, 2, 0);
    run_op("lz", 0, 8'h80, 28'h0800000, 32'h3E800000, 0, 0, 6, 0);
    run_op("zero", 1, 8'h55, 28'h0000000, 32'h00000000, 0, 0, 2, 0);
    run_op("uflow", 0, 8'h02, 28'h1000000, 32'h00400000, 0, 1, 4, 0);
    run_op("denorm", 0, 8'h01, 28'h0000010, 32'h00000002, 0, 1, 3, 0);
    run_op("neg", 1, 8'h81, 28'h6000000, 32'hC0C00000, 0, 0, 3, 0);
    run_op("tie_even", 0, 8'h7F, 28'h4000004, 32'h3F800000, 0, 0, 3, 0);
`ifdef FP_NORM_ROUND_EN
    run_op("rnd_up", 0, 8'h7F, 28'h400000C, 32'h3F800002, 0, 0, 3, 0);
    run_op("rnd_carry", 0, 8'h7F, 28'h7FFFFFC, 32'h40000000, 0, 0, 3, 0);
`else
    run_op("rnd_up", 0, 8'h7F, 28'h400000C, 32'h3F800001, 0, 0, 3, 0);
    run_op("rnd_carry", 0, 8'h7F, 28'h7FFFFFC, 32'h3FFFFFFF, 0, 0, 3, 0);
`endif

    // Long shift sequence interrupted by an asynchronous reset.
    in_sign  = 1'b0;
    in_exp   = 8'h80;
    in_mant  = 28'h0000008;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_result", out_result, 32'd0);
    check("arst_flags", {30'd0, out_overflow, out_underflow}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("post_rst", 0, 8'h80, 28'h0800000, 32'h3E800000, 0, 0, 6, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
